// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: PC generation, in-order request tracking and a DEPTH-entry prefetch
// buffer feeding ID. Define IF_PERF_CNT_EN to add stall/flush performance counters.
module if_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_addr,
  output logic            imem_rd_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int unsigned     AW   = $clog2(DEPTH);
  localparam int unsigned     CW   = AW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] buf_inst [DEPTH];
  logic [XLEN-1:0] buf_pc   [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   occupancy;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW+1:0]   credit_used;
  logic [XLEN-1:0] redirect_pc;
  logic            issue;
  logic            resp_drop;
  logic            resp_keep;
  logic            push;
  logic            pop;

  // Every buffer slot is reserved by a request until it is popped, so a push never overflows.
  assign credit_used = {2'b00, occupancy} + {2'b00, outstanding} + {2'b00, drop_cnt};
  assign issue       = go && !branch && (credit_used < (CW + 2)'(DEPTH));

  assign resp_drop   = imem_rvalid && (drop_cnt != '0);
  assign resp_keep   = imem_rvalid && (drop_cnt == '0);
  assign push        = resp_keep && !branch;
  assign pop         = id_valid && id_ready && !branch;
  assign redirect_pc = branch_addr & ~XLEN'(3);

  assign id_valid    = (occupancy != '0);
  assign id_inst     = buf_inst[rd_ptr];
  assign id_pc       = buf_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      imem_rd_en  <= 1'b0;
      imem_addr   <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      imem_rd_en <= issue;
      if (issue) begin
        imem_addr <= fetch_pc;
        fetch_pc  <= fetch_pc + STEP;
      end
      if (branch) begin
        // Everything still in flight becomes stale; a response landing now is consumed here.
        fetch_pc    <= redirect_pc;
        resp_pc     <= redirect_pc;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        occupancy   <= '0;
        outstanding <= '0;
        drop_cnt    <= drop_cnt + outstanding - CW'(imem_rvalid);
      end else begin
        if (push) begin
          buf_inst[wr_ptr] <= imem_rdata;
          buf_pc[wr_ptr]   <= resp_pc;
          wr_ptr           <= wr_ptr + 1'b1;
          resp_pc          <= resp_pc + STEP;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        occupancy   <= occupancy + CW'(push) - CW'(pop);
        outstanding <= outstanding + CW'(issue) - CW'(resp_keep);
        drop_cnt    <= drop_cnt - CW'(resp_drop);
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (id_valid && !id_ready && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (branch && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    push |-> (occupancy < CW'(DEPTH)));
  a_credit_bound : assert property (@(posedge clk) disable iff (reset)
    credit_used <= (CW + 2)'(DEPTH));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: cycle table for streaming/stall, then branch and
// variable-latency sequences against an in-order IMEM model.
module tb_if_prefetch_unit;

  localparam int DEPTH = 4;
  localparam int NV    = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  if_prefetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .branch      (branch),
    .branch_addr (branch_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // In-order IMEM model; latency fixed or random 1..3.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } req_t;
  req_t        req_q[$];
  logic [31:0] cyc = 0;
  logic [31:0] last_due = 0;
  logic [31:0] due;
  int          fixed_lat = 1;
  bit          lat_rand = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      req_q.delete();
      last_due = 0;
      imem_rvalid <= 1'b0;
    end else begin
      if (imem_rd_en) begin
        due = cyc - 1 + (lat_rand ? $urandom_range(3, 1) : fixed_lat);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        req_q.push_back('{addr: imem_addr, due: due});
      end
      if (req_q.size() != 0 && req_q[0].due <= cyc) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(req_q[0].addr);
        void'(req_q.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
      end
    end
  end

  logic [31:0] acc_pc[$];
  int          inflight = 0;
  bit          prev_go = 1'b1;
  bit          prev_br = 1'b0;

  // One cycle: inputs applied at the negedge, outputs observed at the same point.
  task automatic cycle(input logic g, input logic rdy, input logic br, input logic [31:0] ba);
    @(negedge clk);
    go = g;
    id_ready = rdy;
    branch = br;
    branch_addr = ba;
    if (!reset) begin
      inflight = inflight + int'(imem_rd_en) - int'(imem_rvalid);
      check("inflight_le_depth", 32'(inflight <= DEPTH), 32'd1);
      if (!prev_go || prev_br) check("no_req_when_idle_or_branch", 32'(imem_rd_en), 32'd0);
      if (id_valid && rdy && !br) begin
        check("inst_matches_pc", id_inst, mem_word(id_pc));
        acc_pc.push_back(id_pc);
      end
    end
    prev_go = g;
    prev_br = br;
  endtask

  task automatic branch_test(input string nm, input int lat, input logic [31:0] tgt1,
                             input bit two, input logic [31:0] tgt2, input logic [31:0] start);
    int  wait_cyc;
    bit  seen;
    fixed_lat = lat;
    lat_rand = 1'b0;
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    acc_pc.delete();
    cycle(1'b1, 1'b1, 1'b1, tgt1);
    if (two) cycle(1'b1, 1'b1, 1'b1, tgt2);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check({nm, "_valid_after_flush"}, 32'(id_valid), 32'd0);
    check({nm, "_no_req_after_flush"}, 32'(imem_rd_en), 32'd0);
    seen = 1'b0;
    wait_cyc = 0;
    while (!seen && wait_cyc < 8) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (imem_rd_en) seen = 1'b1;
      else wait_cyc++;
    end
    check({nm, "_redirect_issued"}, 32'(seen), 32'd1);
    if (seen) check({nm, "_redirect_addr"}, imem_addr, start);
    if (lat == 1) check({nm, "_redirect_latency"}, 32'(wait_cyc), 32'd0);
    repeat (14) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check({nm, "_enough_delivered"}, 32'(acc_pc.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < acc_pc.size(); i++) begin
      check({nm, "_stream_pc"}, acc_pc[i], start + 32'(4 * i));
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_rd_en;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[NV];

  initial begin
    // Row k = k cycles after reset release; stall rows 8..17 fill the buffer to DEPTH.
    for (int k = 0; k < NV; k++) begin
      vecs[k].rdy       = (k >= 8 && k <= 17) ? 1'b0 : 1'b1;
      vecs[k].exp_valid = (k >= 3);
      vecs[k].exp_pc    = (k < 3) ? 32'h0 : (k <= 8) ? 32'(4 * (k - 3)) :
                          (k <= 18) ? 32'd20 : 32'(4 * (k - 13));
      vecs[k].exp_rd_en = (k >= 1 && k <= 9) || (k >= 20);
      vecs[k].exp_addr  = (k == 0) ? 32'h0 : (k <= 9) ? 32'(4 * (k - 1)) :
                          (k <= 19) ? 32'd32 : 32'(4 * (k - 11));
    end

    reset = 1'b1;
    go = 1'b1;
    id_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rd_en", 32'(imem_rd_en), 32'd0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_valid", 32'(id_valid), 32'd0);
    check("reset_inst", id_inst, 32'h0);
    check("reset_pc", id_pc, 32'h0);

    for (int k = 0; k < NV; k++) begin
      cycle(1'b1, vecs[k].rdy, 1'b0, 32'h0);
      if (k == 0) reset = 1'b0;
      check($sformatf("vec%0d_rd_en", k), 32'(imem_rd_en), 32'(vecs[k].exp_rd_en));
      check($sformatf("vec%0d_addr", k), imem_addr, vecs[k].exp_addr);
      check($sformatf("vec%0d_valid", k), 32'(id_valid), 32'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) begin
        check($sformatf("vec%0d_pc", k), id_pc, vecs[k].exp_pc);
        check($sformatf("vec%0d_inst", k), id_inst, mem_word(vecs[k].exp_pc));
      end
    end

    branch_test("br100", 2, 32'h100, 1'b0, 32'h0, 32'h100);
    branch_test("br200_300", 1, 32'h200, 1'b1, 32'h300, 32'h300);
    begin
`ifdef IF_PERF_CNT_EN
      logic [31:0] flush_before;
      flush_before = perf_flush_cnt;
`endif
      branch_test("br103", 1, 32'h103, 1'b0, 32'h0, 32'h100);
`ifdef IF_PERF_CNT_EN
      check("perf_flush_delta", perf_flush_cnt - flush_before, 32'd1);
`endif
    end

    // Random latency, go and id_ready toggling: delivery must stay strictly sequential.
    lat_rand = 1'b1;
    acc_pc.delete();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 7), 1'b0, 32'h0);
    end
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("rand_progress", 32'(acc_pc.size() > 20), 32'd1);
    for (int i = 1; i < acc_pc.size(); i++) begin
      check("rand_sequential_pc", acc_pc[i], acc_pc[i-1] + 32'd4);
    end
    check("drain_valid_low", 32'(id_valid), 32'd0);
    check("drain_inflight_zero", 32'(inflight), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Parametrised instruction-fetch stage with its own PC register, in-order memory request tracking and a DEPTH-entry prefetch buffer.
- Sits between the instruction memory (ROM/IMEM) and the ID stage.
- Decouples fetch from decode stalls via a valid/ready handshake to ID.
- Supports branch redirect with a full flush, including discard of responses still in flight.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- DEPTH, 4, prefetch buffer entries and maximum outstanding requests; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- go  in  1  fetch enable; when low, no new requests are issued.
- branch  in  1  redirect pulse from EX.
- branch_addr  in  XLEN  redirect target.
- imem_rd_en  out  1  memory read request, one per cycle max.
- imem_addr  out  XLEN  request address.
- imem_rvalid  in  1  response valid; responses return in order, latency ≥1 cycle.
- imem_rdata  in  XLEN  response instruction.
- id_valid  out  1  head entry available to ID.
- id_ready  in  1  ID accepts the head entry (low = stall).
- id_inst  out  XLEN  head instruction.
- id_pc  out  XLEN  PC of head instruction.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - Buffer empty, outstanding = 0, drop_cnt = 0.
  - imem_rd_en = 0, imem_addr = RESET_PC.
  - id_valid = 0, id_inst = 0, id_pc = 0.
- Reset has priority over all other inputs. Reset mid-operation discards buffer and in-flight tracking; responses arriving after reset is released are discarded only if drop_cnt requires it, which after reset it does not. Integration must hold IMEM idle across reset.
- Request issue (registered):
  - imem_rd_en asserts in the cycle after go && !branch && (occupancy + outstanding + drop_cnt) < DEPTH.
  - imem_addr = fetch_pc; fetch_pc += PC_STEP per issued request, modulo 2^XLEN wrap.
- Response handling:
  - On imem_rvalid with drop_cnt > 0: response is discarded and drop_cnt decrements.
  - Otherwise: {imem_rdata, resp_pc} is pushed into the buffer and resp_pc += PC_STEP.
  - outstanding decrements on every response that is not dropped.
- Credit rule guarantees a push never hits a full buffer. An overflow condition is a design error, covered by assertion.
- Dequeue:
  - id_valid = buffer not empty; id_inst/id_pc show the head.
  - Pop on id_valid && id_ready.
  - Push-to-id_valid latency is 1 cycle; no bypass.
  - Simultaneous push and pop is legal at any occupancy.
- Branch (cycle T):
  - Buffer cleared at the T edge; id_valid = 0 in T+1.
  - fetch_pc = resp_pc = {branch_addr[XLEN-1:2], 2'b00}.
  - drop_cnt += requests in flight at T, counting a request issued at T and excluding one returning at T.
  - No request issued in T; first redirect request in T+1 if go.
  - Branch overrides a pop or push in the same cycle.
  - A back-to-back branch accumulates into drop_cnt.
- go low: outstanding responses still land; buffer still drains to ID; fetch_pc frozen.
- Counters (occupancy, outstanding, drop_cnt) are $clog2(DEPTH)+1 bits wide.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt (32 b) and perf_flush_cnt (32 b).
  - perf_stall_cnt increments each cycle id_valid && !id_ready.
  - perf_flush_cnt increments per branch.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, go=1, 1-cycle IMEM, id_ready=1:
  - Requests at 0x0, 0x4, 0x8, …
  - First id_valid 3 cycles after reset release with id_pc=0x0.
  - One instruction per cycle thereafter, in order.
- id_ready held low 10 cycles, DEPTH=4:
  - Buffer fills to 4.
  - imem_rd_en deasserts once occupancy + outstanding = 4.
  - On release, entries drain in PC order with no loss or duplication.
- Branch to 0x100 with 2 requests in flight:
  - The 2 stale responses are dropped.
  - Next id_pc = 0x100, then 0x104.
- Branch on consecutive cycles, to 0x200 then 0x300:
  - Only 0x300 stream delivered; no 0x200 entry ever reaches ID.
- Variable latency 1–3 cycles with go toggling:
  - id_pc strictly sequential by PC_STEP; outstanding never exceeds DEPTH.
- branch_addr=0x103:
  - Fetch restarts at 0x100.
  - With IF_PERF_CNT_EN defined, perf_flush_cnt increments by 1.
